// File: rtl/knight_rider_pkg.sv
// Shared types and helpers for the Larson scanner: select/direction types and
// the head PWM duty lookup.
package knight_rider_pkg;

  localparam int PWM_BITS = 4;

  typedef logic [1:0] sel_t;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_t;

  // Head duty in sixteenths: 4, 8, 12 or 16 (16 = always on).
  function automatic logic [PWM_BITS:0] head_duty(input sel_t sel);
    head_duty = {1'b0, sel, 2'b00} + 5'd4;
  endfunction

endpackage

// File: rtl/knight_rider_scanner_button_sync_edge.sv
// Button conditioning: 2-flop synchronizer for an asynchronous push button
// followed by a single-cycle rising-edge pulse.
module button_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  logic sync1;
  logic sync2;
  logic prev;

  // Synchronizer chain plus one history flop for edge detection.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      prev  <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      prev  <= sync2;
    end
  end

  assign pulse = sync2 & ~prev;

endmodule

// File: rtl/knight_rider_scanner.sv
// Larson scanner on the 8-in/8-out pad-ring wrapper: bouncing PWM head LED with
// button-selected speed and brightness. Define KNIGHT_RIDER_TRAIL_EN for a two-LED fading trail.
module knight_rider_scanner
  import knight_rider_pkg::*;
#(
  parameter int OUT_WIDTH = 8,
  parameter int STEP_DIV  = 64
) (
  input  logic [7:0]           io_in,
  output logic [OUT_WIDTH-1:0] io_out
);

  localparam int POS_W = $clog2(OUT_WIDTH);
  localparam int CNT_W = $clog2(8 * STEP_DIV) + 1;
  localparam logic [POS_W-1:0] POS_MAX = POS_W'(OUT_WIDTH - 1);
  localparam logic [POS_W-1:0] POS_PEN = POS_W'(OUT_WIDTH - 2);

  logic clk;
  logic rst_n;
  logic unused_pins;
  assign clk         = io_in[0];
  assign rst_n       = io_in[1];
  assign unused_pins = ^io_in[7:4];

  logic rate_pulse;
  logic bright_pulse;

  button_sync_edge u_rate_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (io_in[2]),
    .pulse (rate_pulse)
  );

  button_sync_edge u_bright_btn (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (io_in[3]),
    .pulse (bright_pulse)
  );

  logic [POS_W-1:0]    pos;
  logic [POS_W-1:0]    pos_nxt;
  dir_t                dir;
  dir_t                dir_nxt;
  sel_t                speed_sel;
  sel_t                bright_sel;
  logic [CNT_W-1:0]    step_cnt;
  logic [CNT_W-1:0]    interval;
  logic                step;
  logic [PWM_BITS-1:0] pwm_cnt;
  logic [PWM_BITS:0]   head_d;
  logic [OUT_WIDTH-1:0] led;

  // Greater-or-equal lets a mid-count speed-up step immediately.
  assign interval = CNT_W'(STEP_DIV) << (2'd3 - speed_sel);
  assign step     = (step_cnt >= (interval - CNT_W'(1)));
  assign head_d   = head_duty(bright_sel);

  // Next head position and direction; endpoints reflect without a double dwell.
  always_comb begin
    pos_nxt = pos;
    dir_nxt = dir;
    if (step) begin
      case (dir)
        DIR_UP: begin
          if (pos == POS_MAX) begin
            dir_nxt = DIR_DOWN;
            pos_nxt = POS_PEN;
          end else begin
            pos_nxt = pos + POS_W'(1);
          end
        end
        DIR_DOWN: begin
          if (pos == {POS_W{1'b0}}) begin
            dir_nxt = DIR_UP;
            pos_nxt = POS_W'(1);
          end else begin
            pos_nxt = pos - POS_W'(1);
          end
        end
        default: begin
          dir_nxt = DIR_UP;
          pos_nxt = {POS_W{1'b0}};
        end
      endcase
    end else begin
      pos_nxt = pos;
    end
  end

  // Core state: head, timers, selects and the registered LED drive.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pos        <= {POS_W{1'b0}};
      dir        <= DIR_UP;
      speed_sel  <= 2'd0;
      bright_sel <= 2'd3;
      step_cnt   <= {CNT_W{1'b0}};
      pwm_cnt    <= {PWM_BITS{1'b0}};
      io_out     <= {OUT_WIDTH{1'b0}};
    end else begin
      pos      <= pos_nxt;
      dir      <= dir_nxt;
      step_cnt <= step ? {CNT_W{1'b0}} : (step_cnt + CNT_W'(1));
      pwm_cnt  <= pwm_cnt + PWM_BITS'(1);
      if (rate_pulse) begin
        speed_sel <= speed_sel + 2'd1;
      end
      if (bright_pulse) begin
        bright_sel <= bright_sel + 2'd1;
      end
      io_out <= led;
    end
  end

`ifdef KNIGHT_RIDER_TRAIL_EN
  logic [POS_W-1:0] p1;
  logic [POS_W-1:0] p2;
  logic             p1_valid;
  logic             p2_valid;

  // Trail history shifts once per head step.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      p1       <= {POS_W{1'b0}};
      p2       <= {POS_W{1'b0}};
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
    end else if (step) begin
      p2       <= p1;
      p2_valid <= p1_valid;
      p1       <= pos;
      p1_valid <= 1'b1;
    end
  end

  // LED pattern; the head is written last so it overrides a coinciding trail.
  always_comb begin
    led = {OUT_WIDTH{1'b0}};
    if (p2_valid && ({1'b0, pwm_cnt} < (head_d >> 2))) begin
      led[p2] = 1'b1;
    end else begin
      led = led;
    end
    if (p1_valid && ({1'b0, pwm_cnt} < (head_d >> 1))) begin
      led[p1] = 1'b1;
    end else begin
      led = led;
    end
    led[pos] = ({1'b0, pwm_cnt} < head_d);
  end
`else
  // LED pattern: only the PWM-modulated head.
  always_comb begin
    led      = {OUT_WIDTH{1'b0}};
    led[pos] = ({1'b0, pwm_cnt} < head_d);
  end
`endif

endmodule

// File: tb/tb_knight_rider_scanner.sv
// Directed bench for knight_rider_scanner with STEP_DIV=4 (step interval 32 at
// reset); trail checks apply when KNIGHT_RIDER_TRAIL_EN is defined.
module tb_knight_rider_scanner;

  logic       clk;
  logic       rst;
  logic       rate;
  logic       bright;
  logic [7:0] io_in;
  logic [7:0] io_out;
  int         vectors;
  int         miscompares;
  int         ncyc;

  assign io_in = {4'b1010, bright, rate, rst, clk};

  knight_rider_scanner #(.OUT_WIDTH(8), .STEP_DIV(4)) dut (
    .io_in  (io_in),
    .io_out (io_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Head at bit b: exact pattern without trail, head bit only with trail.
  task automatic check_head(input string tag, input int b);
    logic [7:0] m;
    m = 8'd1 << b;
`ifdef KNIGHT_RIDER_TRAIL_EN
    check(tag, {31'd0, io_out[b]}, 32'd1);
`else
    check(tag, {24'd0, io_out}, {24'd0, m});
`endif
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    ncyc++;
  endtask

  task automatic run_to(input int n);
    while (ncyc < n) tick();
  endtask

  task automatic apply_reset(input logic r, input logic b);
    rst = 1'b0;
    rate = 1'b0;
    bright = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    check("reset_out", {24'd0, io_out}, 32'h00);
    rate = r;
    bright = b;
    rst = 1'b1;
    ncyc = 0;
  endtask

  task automatic rate_pulse();
    rate = 1'b1;
    repeat (5) tick();
    rate = 1'b0;
    repeat (5) tick();
  endtask

  // Clocks between two consecutive io_out changes (1000 means timeout).
  task automatic measure(output int n);
    logic [7:0] last;
    int guard;
    last = io_out;
    guard = 0;
    while (io_out === last && guard < 1000) begin
      tick();
      guard++;
    end
    last = io_out;
    n = 0;
    while (io_out === last && n < 1000) begin
      tick();
      n++;
    end
  endtask

  initial begin
    int iv;
    int c_a;
    int c_b;
    int c_c;
    logic [7:0] e;
    rst = 1'b0;
    rate = 1'b0;
    bright = 1'b0;
    vectors = 0;
    miscompares = 0;
    ncyc = 0;

    // Plain scan from reset: interval 32, bounce at both ends.
    apply_reset(1'b0, 1'b0);
    run_to(1);
    check("release", {24'd0, io_out}, 32'h01);
    run_to(32);
    check("first_dwell", {24'd0, io_out}, 32'h01);
    run_to(33);
    check_head("first_step", 1);
`ifdef KNIGHT_RIDER_TRAIL_EN
    run_to(97);
    c_a = 0; c_b = 0; c_c = 0;
    for (int i = 0; i < 16; i++) begin
      c_a += io_out[3];
      c_b += io_out[2];
      c_c += io_out[1];
      tick();
    end
    check("trail_head_duty", c_a, 16);
    check("trail_p1_duty", c_b, 8);
    check("trail_p2_duty", c_c, 4);
`endif
    run_to(224);
    check_head("before_top", 6);
    run_to(225);
    check_head("top_reached", 7);
    run_to(256);
    check_head("top_dwell", 7);
    run_to(257);
    check_head("top_bounce", 6);
`ifdef KNIGHT_RIDER_TRAIL_EN
    c_a = 0; c_b = 0;
    for (int i = 0; i < 16; i++) begin
      c_a += io_out[6];
      c_b += io_out[7];
      tick();
    end
    check("bounce_head_duty", c_a, 16);
    check("bounce_p1_duty", c_b, 8);
`endif
    run_to(449);
    check_head("low_reached", 0);
    run_to(480);
    check_head("low_dwell", 0);
    run_to(481);
    check_head("low_bounce", 1);

    // Speed button: one pulse gives interval 16, four pulses wrap back to 32.
    apply_reset(1'b1, 1'b0);
    run_to(5);
    rate = 1'b0;
    run_to(16);
    check("speed1_dwell", {24'd0, io_out}, 32'h01);
    run_to(17);
    check_head("speed1_step", 1);
`ifndef KNIGHT_RIDER_TRAIL_EN
    measure(iv);
    check("interval_sel1", iv, 16);
    rate_pulse();
    measure(iv);
    check("interval_sel2", iv, 8);
    rate_pulse();
    measure(iv);
    check("interval_sel3", iv, 4);
    rate_pulse();
    measure(iv);
    check("interval_wrap", iv, 32);
`endif

    // Brightness button: 3 wraps to 0, head on for pwm_cnt 0..3 only.
    apply_reset(1'b0, 1'b1);
    run_to(5);
    bright = 1'b0;
    run_to(16);
    c_a = 0;
    for (int k = 17; k <= 32; k++) begin
      tick();
      e = (((k - 1) % 16) < 4) ? 8'h01 : 8'h00;
      check("duty4_sample", {24'd0, io_out}, {24'd0, e});
      c_a += io_out[0];
    end
    check("duty4_count", c_a, 4);

    // Reset mid-scan with speed_sel=2 restores full state.
    apply_reset(1'b1, 1'b0);
    run_to(5);
    rate = 1'b0;
    run_to(10);
    rate = 1'b1;
    run_to(15);
    rate = 1'b0;
    run_to(60);
    rst = 1'b0;
    tick();
    check("midscan_reset", {24'd0, io_out}, 32'h00);
    tick();
    rst = 1'b1;
    ncyc = 0;
    run_to(1);
    check("post_reset", {24'd0, io_out}, 32'h01);
    run_to(16);
    check("post_reset_mid", {24'd0, io_out}, 32'h01);
    run_to(32);
    check("post_reset_dwell", {24'd0, io_out}, 32'h01);
    run_to(33);
    check_head("post_reset_step", 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
